fifo_rd_ctrl: RTL



---
 rtl/fifo_rd_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_rd_ctrl                                               |
// | Description : Read-side controller for fifo_sync. Issues rd_en while the |
// |               FIFO is non-empty and there is room downstream, captures   |
// |               the word one cycle later and presents it on a valid/ready  |
// |               stream through a 2-entry skid buffer.                      |
// | Options     : define FIFO_RD_CTRL_STATS_EN to add the 32-bit pop_count   |
// |               output (delivered-word counter, cleared only by rst).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_rd_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data_out,
   output logic             fifo_rd_en,
   input  logic             flush,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [1:0]       occupancy
`ifdef FIFO_RD_CTRL_STATS_EN
   ,
   output logic [31:0]      pop_count
`endif
);

   // Skid buffer depth; reads are only issued while the committed level
   // (held + in flight - leaving) stays below this.
   localparam logic [2:0] c_SKID_DEPTH = 3'd2;

   logic [1:0]       r_occ;
   logic             r_pend;
   logic [WIDTH-1:0] r_ent0;
   logic [WIDTH-1:0] r_ent1;

   logic             w_xfer;
   logic [2:0]       w_level;
   logic [1:0]       w_occ_shift;
   logic [1:0]       w_occ_nxt;
   logic [WIDTH-1:0] w_ent0_nxt;
   logic [WIDTH-1:0] w_ent1_nxt;

   assign m_valid   = (r_occ != 2'd0);
   assign m_data    = r_ent0;
   assign occupancy = r_occ;
   assign w_xfer    = m_valid & m_ready;

   // Words committed to the skid buffer after this edge if no new read is issued.
   assign w_level = {1'b0, r_occ} + {2'b0, r_pend} - {2'b0, w_xfer};

   // Read issue: never while empty, flushing or in reset, and never beyond
   // what the skid buffer can absorb, so it cannot overflow.
   assign fifo_rd_en = ~rst & ~flush & ~fifo_empty & (w_level < c_SKID_DEPTH);

   // Next skid contents: shift out the head on a transfer, then write the
   // in-flight word into the first free slot after that shift.
   always_comb begin
      w_occ_shift = r_occ - {1'b0, w_xfer};
      w_ent0_nxt  = r_ent0;
      w_ent1_nxt  = r_ent1;
      if (w_xfer) begin
         w_ent0_nxt = r_ent1;
      end
      if (r_pend) begin
         if (w_occ_shift == 2'd0) begin
            w_ent0_nxt = fifo_data_out;
         end else begin
            w_ent1_nxt = fifo_data_out;
         end
      end
      w_occ_nxt = w_occ_shift + {1'b0, r_pend};
   end

   // Skid buffer and in-flight flag; flush drops held and pending words.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ  <= 2'd0;
         r_pend <= 1'b0;
         r_ent0 <= '0;
         r_ent1 <= '0;
      end else if (flush) begin
         r_occ  <= 2'd0;
         r_pend <= 1'b0;
      end else begin
         r_occ  <= w_occ_nxt;
         r_pend <= fifo_rd_en;
         r_ent0 <= w_ent0_nxt;
         r_ent1 <= w_ent1_nxt;
      end
   end

`ifdef FIFO_RD_CTRL_STATS_EN
   logic [31:0] r_pop_count;

   // Delivered-word counter; survives flush, wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pop_count <= 32'd0;
      end else if (w_xfer) begin
         r_pop_count <= r_pop_count + 32'd1;
      end
   end

   assign pop_count = r_pop_count;
`endif

endmodule
`default_nettype wire
